// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extender with a 2-entry skid buffer; flush squashes held entries; IMM_BRANCH_EN adds the <<2 branch mode; ports clk reset flush in_valid in_ready imm_in mode out_valid out_ready out_data
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic [OUT_W-1:0] or_q, or_d, sk_q, sk_d;
  logic [OUT_W-1:0] sign_ext, zero_ext, upper_ext, br_ext, ext;
  logic accept, consume;
  assign sign_ext  = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};
  assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, imm_in};
  assign upper_ext = {imm_in, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_BRANCH_EN
  assign br_ext = sign_ext << 2;
`else
  assign br_ext = sign_ext;
`endif
  assign ext = mode == 2'd1 ? zero_ext : mode == 2'd2 ? upper_ext : mode == 2'd3 ? br_ext : sign_ext;
  assign in_ready  = state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign out_data  = or_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  always_comb begin
    state_d = flush ? EMPTY
            : state_q == EMPTY ? (accept ? ONE : EMPTY)
            : state_q == ONE ? ((accept && !consume) ? TWO : (consume && !accept) ? EMPTY : ONE)
            : (consume ? ONE : TWO);
    or_d = flush ? or_q
         : (accept && (state_q == EMPTY || consume)) ? ext
         : (state_q == TWO && consume) ? sk_q
         : or_q;
    sk_d = (!flush && accept && state_q == ONE && !consume) ? ext : sk_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
    end
  end
endmodule
